// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and ID-width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request bit found searching upward from ptr, wrapping.
module rr_priority_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    int   pos;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 30,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [ID_W+DATA_W-1:0]  fifo_data,
    output logic                    busy,
    output logic [ID_W-1:0]         owner_id
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t            state, state_n;
    logic [ID_W-1:0]   owner, owner_n;
    logic [ID_W-1:0]   rr_ptr, rr_n;
    logic [CNT_W-1:0]  beats, beats_n;
    logic [ID_W-1:0]   nxt_ptr, pick_ptr, pick_idx;
    logic [N_REQ-1:0]  own_oh, pick_req, pick_grant;
    logic [DATA_W-1:0] own_data;
    logic              own_valid, fire, rel, pick_any;

    assign busy      = (state == BURST);
    assign own_oh    = N_REQ'(1) << owner;
    assign own_valid = req_valid[owner];
    assign own_data  = req_data[int'(owner)*DATA_W +: DATA_W];
    assign nxt_ptr   = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    assign fire      = busy && own_valid && !fifo_full;
    assign req_ready = (busy && !fifo_full) ? own_oh : '0;
    assign fifo_wr   = fire;
    assign fifo_data = busy ? {owner, own_data} : '0;
    assign owner_id  = busy ? owner : '0;

    // One picker serves both the IDLE grant and the handoff; a handoff excludes the
    // outgoing owner and searches from the slot after it.
    assign pick_req  = busy ? (req_valid & ~own_oh) : req_valid;
    assign pick_ptr  = busy ? nxt_ptr : rr_ptr;
    assign pick_any  = |pick_grant;
    assign rel       = busy && (!own_valid || (fire && beats == LAST_BEAT));

    rr_priority_picker #(.N_REQ(N_REQ)) picker (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        beats_n = beats;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = BURST;
                    owner_n = pick_idx;
                    beats_n = '0;
                end
            end
            BURST: begin
                if (fire) beats_n = beats + 1'b1;
                if (rel) begin
                    beats_n = '0;
                    rr_n    = nxt_ptr;
                    if (pick_any) begin
                        owner_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
                beats_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            beats  <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_n;
            beats  <= beats_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter with N_REQ=4, DATA_W=30, MAX_BURST=4.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 30;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr;
    logic [IW+DW-1:0] fifo_data;
    logic            busy;
    logic [IW-1:0]   owner_id;

    int checks   = 0;
    int failures = 0;

    logic [27:0] seq [N];
    logic [27:0] sb  [N];
    int          waitc [N];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy),
        .owner_id  (owner_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b, input logic w,
                           input logic [N-1:0] rdy, input logic [IW-1:0] id,
                           input logic [IW+DW-1:0] d);
        chk({tag, "_busy"},  busy,      b);
        chk({tag, "_wr"},    fifo_wr,   w);
        chk({tag, "_ready"}, req_ready, rdy);
        chk({tag, "_id"},    owner_id,  id);
        chk({tag, "_data"},  fifo_data, d);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        fifo_full = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, including requests presented while reset is held
        #1;
        chk_out("rst", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        req_valid = 4'b1111;
        #1;
        chk_out("rst_held", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        chk("rst_held_edge_busy", busy, 1'b0);
        rst = 1'b0;
        req_valid = '0;

        // Single requester, six words: 4-beat burst, one regrant cycle, 2 more beats
        req_valid = 4'b0001;
        set_data(0, 30'h10);
        #1 chk_out("r30_idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_data(0, 30'(32'h10 + k));
            #1 chk_out("r30_beat", 1'b1, 1'b1, 4'b0001, 2'd0, {2'd0, 30'(32'h10 + k)});
            cyc();
        end
        set_data(0, 30'h14);
        #1 chk_out("r30_regrant", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(0, 30'(32'h14 + k));
            #1 chk_out("r30_beat2", 1'b1, 1'b1, 4'b0001, 2'd0, {2'd0, 30'(32'h14 + k)});
            cyc();
        end
        req_valid = 4'b0000;
        #1 chk_out("r30_drop", 1'b1, 1'b0, 4'b0001, 2'd0, {2'd0, 30'h15});
        cyc();
        #1 chk_out("r30_idle2", 1'b0, 1'b0, 4'b0000, 2'd0, '0);

        // All four valid: back-to-back 4-beat bursts 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 30'(32'h100 + i));
        req_valid = 4'b1111;
        #1 chk_out("r31_idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < MB; b++) begin
                #1 chk_out($sformatf("r31_g%0d_b%0d", g, b), 1'b1, 1'b1, 4'(1 << (g % N)),
                           2'(g % N), {2'(g % N), 30'(32'h100 + (g % N))});
                cyc();
            end
        end

        // FIFO full for 3 cycles mid-burst by ID 2
        do_reset();
        set_data(2, 30'h2AA);
        req_valid = 4'b0100;
        #1 chk_out("r32_idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        for (int b = 0; b < 2; b++) begin
            #1 chk_out("r32_pre", 1'b1, 1'b1, 4'b0100, 2'd2, {2'd2, 30'h2AA});
            cyc();
        end
        fifo_full = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1 chk_out("r32_full", 1'b1, 1'b0, 4'b0000, 2'd2, {2'd2, 30'h2AA});
            cyc();
        end
        fifo_full = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1 chk_out("r32_post", 1'b1, 1'b1, 4'b0100, 2'd2, {2'd2, 30'h2AA});
            cyc();
        end
        #1 chk_out("r32_done", 1'b0, 1'b0, 4'b0000, 2'd0, '0);

        // Owner 1 drops after 2 beats; hand off to 3 (search from 2 skips valid ID 0)
        do_reset();
        set_data(0, 30'h0AB);
        set_data(1, 30'h111);
        set_data(3, 30'h333);
        req_valid = 4'b0010;
        #1 chk_out("r33_idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        req_valid = 4'b1011;
        for (int b = 0; b < 2; b++) begin
            #1 chk_out("r33_own1", 1'b1, 1'b1, 4'b0010, 2'd1, {2'd1, 30'h111});
            cyc();
        end
        req_valid = 4'b1001;
        #1 chk_out("r33_drop", 1'b1, 1'b0, 4'b0010, 2'd1, {2'd1, 30'h111});
        cyc();
        for (int b = 0; b < 2; b++) begin
            #1 chk_out("r33_own3", 1'b1, 1'b1, 4'b1000, 2'd3, {2'd3, 30'h333});
            cyc();
        end

        // Reset during beat 3 of owner 3's burst; next grant goes to ID 0
        #1 chk("r34_pre_wr", fifo_wr, 1'b1);
        rst = 1'b1;
        #1 chk_out("r34_rst", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        rst = 1'b0;
        req_valid = 4'b1111;
        #1 chk_out("r34_idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0);
        cyc();
        #1 chk_out("r34_grant", 1'b1, 1'b1, 4'b0001, 2'd0, {2'd0, 30'h0AB});
        cyc();

        // Random valid/full traffic with per-ID scoreboard and wait-bound tracking
        do_reset();
        for (int i = 0; i < N; i++) begin
            seq[i]   = '0;
            sb[i]    = '0;
            waitc[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                set_data(i, {2'(i), seq[i]});
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_no_wr_full", fifo_wr & fifo_full, 1'b0);
            chk("rnd_ready_owner", req_ready & ~(busy ? (4'(1) << owner_id) : 4'b0000), 4'b0000);
            if (fifo_wr) begin
                chk("rnd_sb", fifo_data, {owner_id, owner_id, sb[owner_id]});
                sb[owner_id] = sb[owner_id] + 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) seq[i] = seq[i] + 1'b1;
                if (!req_valid[i] || (busy && owner_id == 2'(i))) waitc[i] = 0;
                else if (fifo_wr) waitc[i]++;
                chk("rnd_wait_bound", waitc[i] > (N - 1) * MB, 1'b0);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 30, payload width per requester.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant (1..16).
REQ-004 SHALL have derived constant ID_W = clog2(N_REQ), minimum 1.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester word-available flag.
REQ-008 SHALL have port req_data  input  N_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready  output  N_REQ  per-requester accept strobe; a beat transfers when valid and ready are both high.
REQ-010 SHALL have port fifo_full  input  1  full flag from the shared FIFO.
REQ-011 SHALL have port fifo_wr  output  1  FIFO write strobe.
REQ-012 SHALL have port fifo_data  output  ID_W+DATA_W  FIFO word: {owner ID, payload}.
REQ-013 SHALL have port busy  output  1  high while a requester owns the FIFO write port.
REQ-014 SHALL have port owner_id  output  ID_W  index of the current owner; 0 when not busy.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no owner) and BURST (owner locked).
REQ-016 In IDLE with any req_valid high, SHALL select the owner round-robin, starting the search at rr_ptr, and enter BURST on the next edge; no transfer occurs in that cycle.
REQ-017 In BURST, req_ready[owner] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-018 fifo_wr SHALL equal req_valid[owner] && req_ready[owner] combinationally; fifo_data SHALL be {owner, req_data[owner]}, with zero added latency.
REQ-019 Each transferred beat SHALL increment a beat counter; a cycle stalled on fifo_full or on !req_valid[owner] SHALL NOT increment it.
REQ-020 The owner SHALL be released in the cycle where its beat reaches MAX_BURST, or in any cycle where req_valid[owner] is low.
REQ-021 On release, rr_ptr SHALL become (owner+1) mod N_REQ and the beat counter SHALL clear.
REQ-022 On release, if any other requester is valid, SHALL hand off directly to the round-robin winner and remain in BURST; otherwise SHALL return to IDLE. The released owner is eligible only if no other requester is valid.
REQ-023 The owner SHALL NOT change while fifo_full is high and the owner's valid is high.
REQ-024 A write SHALL never be issued while fifo_full is high.
REQ-025 SHALL guarantee that no valid requester waits more than (N_REQ-1)*MAX_BURST transferred beats for a grant.

Reset
REQ-026 On rst: state IDLE, rr_ptr 0, beat counter 0, owner 0; req_ready 0, fifo_wr 0, fifo_data 0, busy 0, owner_id 0.
REQ-027 rst asserted mid-burst SHALL abort the burst immediately; any beat not yet clocked into the FIFO is lost, and no partial-beat signalling is required.

Structure
REQ-028 The FSM state encoding and the ID-width helper function SHALL reside in the shared project package.
REQ-029 Round-robin selection SHALL be a sub-module, rr_priority_picker (inputs: request vector and pointer; outputs: one-hot winner and index), reused for both the IDLE grant and the handoff.

Verification
REQ-030 Reset followed by req_valid=4'b0001 with six words (0x10..0x15), FIFO not full, MAX_BURST=4 -> words 0x10..0x13 with ID 0; one cycle of regrant; then 0x14..0x15.
REQ-031 All four requesters valid continuously -> bursts of 4 beats, granted to IDs 0,1,2,3,0; no idle cycle between owners.
REQ-032 fifo_full held high for 3 cycles mid-burst by ID 2 -> fifo_wr=0 and req_ready=0 for those cycles; owner stays 2; beat count resumes at 2 of 4 afterwards.
REQ-033 Owner ID 1 drops valid after 2 beats while ID 3 is valid -> handoff to ID 3 in the same cycle; rr_ptr becomes 2.
REQ-034 rst asserted during beat 3 of a burst -> busy, fifo_wr and req_ready are 0 immediately; the next grant after release goes to ID 0.
REQ-035 Random valid/full stimulus for 10k cycles -> no write while full, FIFO contents match a scoreboard per ID, and the wait bound in REQ-025 is never exceeded.
